dm_mem_responder: RTL and testbench

Responder (target) end of the core's instruction/data memory interface for the debug-memory address window.
- The core redirects fetches to this window on halt and on a debug-mode exception; the exception address is `BaseAddr + ExceptionAddress`.
- This block answers those fetches from a tiny fixed ROM and tracks the halt/resume/exception state shared with the debug module.
- Sits beside the core's fetch port, behind the address decoder selecting the debug-memory region.

---
 rtl/dm_mem_pkg.sv | 23 ++
 rtl/dm_rsp_pipe.sv | 31 +++
 rtl/dm_mem_responder.sv | 120 ++++++++++++
 tb/tb_dm_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_mem_pkg.sv
// rtl/dm_mem_pkg.sv - shared types and instruction constants for the debug-memory responder
package dm_mem_pkg;

    typedef enum logic [1:0] {
        RUNNING  = 2'd0,
        HALTED   = 2'd1,
        RESUMING = 2'd2
    } dm_state_e;

    // One in-flight response plus the side-effect pulses that travel with it
    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
        logic        exc;
        logic        ack;
    } dm_rsp_t;

    localparam logic [31:0] LoopInsn = 32'h0000006F;
    localparam logic [31:0] DretInsn = 32'h7B200073;
    localparam logic [31:0] NopInsn  = 32'h00000013;

endpackage

// File: rtl/dm_rsp_pipe.sv
// rtl/dm_rsp_pipe.sv - fixed-depth response delay line with synchronous flush
module dm_rsp_pipe
    import dm_mem_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic    clk,
    input  logic    flush,
    input  dm_rsp_t rsp_in,
    output dm_rsp_t rsp_out
);

    dm_rsp_t stage_q [Depth];

    // Shift every cycle; flush drops everything in flight
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= rsp_in;
            for (int i = 1; i < int'(Depth); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign rsp_out = stage_q[Depth-1];

endmodule

// File: rtl/dm_mem_responder.sv
// rtl/dm_mem_responder.sv - debug-memory window target: ROM responses and halt/resume tracking
module dm_mem_responder
    import dm_mem_pkg::*;
#(
    parameter logic [31:0] BaseAddr         = 32'd1,
    parameter logic [31:0] HaltAddress      = 32'd10,
    parameter logic [31:0] ExceptionAddress = 32'd12,
    parameter logic [31:0] WindowSize       = 32'd256,
    parameter int unsigned RespLatency      = 1,
    parameter logic [31:0] LoopInsnP        = LoopInsn,
    parameter logic [31:0] DretInsnP        = DretInsn,
    parameter logic [31:0] NopInsnP         = NopInsn
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        halted_o,
    input  logic        resume_req_i,
    output logic        resume_ack_o,
    output logic        exception_o,
    output logic [7:0]  exc_count_o
);

    localparam logic [31:0] HaltHitAddr = BaseAddr + HaltAddress;
    localparam logic [31:0] ExcHitAddr  = BaseAddr + ExceptionAddress;

    dm_state_e   state_q;
    logic        halted_q;
    logic [7:0]  exc_count_q;
    logic        in_win;
    logic        halt_hit;
    logic        exc_hit;
    logic        rd_ok;
    dm_rsp_t     rsp_d;
    dm_rsp_t     rsp_q;
    logic        unused_ok;

    // Writes carry no payload into this window
    assign unused_ok = ^{be_i, wdata_i};

    assign gnt_o    = req_i;
    assign in_win   = (addr_i - BaseAddr) < WindowSize;
    assign halt_hit = (addr_i == HaltHitAddr);
    assign exc_hit  = (addr_i == ExcHitAddr) && !halt_hit;
    assign rd_ok    = req_i && !we_i && in_win;

    // Build the response for the request accepted this cycle
    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = req_i;
        if (rd_ok) begin
            if (halt_hit) begin
                if (state_q == RESUMING) begin
                    rsp_d.rdata = DretInsnP;
                    rsp_d.ack   = 1'b1;
                end else begin
                    rsp_d.rdata = LoopInsnP;
                end
            end else if (exc_hit) begin
                rsp_d.rdata = LoopInsnP;
                rsp_d.exc   = 1'b1;
            end else begin
                rsp_d.rdata = NopInsnP;
            end
        end else if (req_i) begin
            rsp_d.err = 1'b1;
        end
    end

    // Halt/resume state machine with registered halted flag and exception counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUNNING;
            halted_q    <= 1'b0;
            exc_count_q <= 8'd0;
        end else if (rd_ok && exc_hit) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
            if (exc_count_q != 8'hFF) begin
                exc_count_q <= exc_count_q + 8'd1;
            end
        end else if (rd_ok && halt_hit && state_q == RESUMING) begin
            state_q  <= RUNNING;
            halted_q <= 1'b0;
        end else if (rd_ok && halt_hit && state_q == RUNNING) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
        end else if (state_q == HALTED && resume_req_i) begin
            // a halt-loop fetch in this same cycle already got LoopInsn
            state_q  <= RESUMING;
            halted_q <= 1'b1;
        end
    end

    dm_rsp_pipe #(
        .Depth (RespLatency)
    ) u_rsp_pipe (
        .clk     (clk_i),
        .flush   (rst_i),
        .rsp_in  (rsp_d),
        .rsp_out (rsp_q)
    );

    assign rvalid_o     = rsp_q.valid;
    assign rdata_o      = rsp_q.valid ? rsp_q.rdata : 32'd0;
    assign err_o        = rsp_q.valid & rsp_q.err;
    assign exception_o  = rsp_q.valid & rsp_q.exc;
    assign resume_ack_o = rsp_q.valid & rsp_q.ack;
    assign halted_o     = halted_q;
    assign exc_count_o  = exc_count_q;

endmodule

// File: tb/tb_dm_mem_responder.sv
// tb/tb_dm_mem_responder.sv - self-checking bench for dm_mem_responder
module tb_dm_mem_responder;

    localparam logic [31:0] LOOP = 32'h0000006F;
    localparam logic [31:0] DRET = 32'h7B200073;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam bit I = 1'b1;
    localparam bit O = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req, we, rsm;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt, rvalid, err, halted, rack, exc;
    logic [31:0] rdata;
    logic [7:0]  cnt;

    logic        req3, we3, rsm3;
    logic [31:0] addr3;
    logic        gnt3, rvalid3, err3, halted3, rack3, exc3;
    logic [31:0] rdata3;
    logic [7:0]  cnt3;

    dm_mem_responder dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .halted_o(halted), .resume_req_i(rsm), .resume_ack_o(rack), .exception_o(exc),
        .exc_count_o(cnt)
    );

    dm_mem_responder #(.RespLatency(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .gnt_o(gnt3), .addr_i(addr3), .we_i(we3),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3),
        .halted_o(halted3), .resume_req_i(rsm3), .resume_ack_o(rack3), .exception_o(exc3),
        .exc_count_o(cnt3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Directed vectors: one accepted request per row, outputs checked one cycle later
    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          we;
        bit          rsm;
        bit          v;
        logic [31:0] d;
        bit          e;
        bit          x;
        bit          k;
        bit          h;
        logic [7:0]  c;
    } vec_t;
    vec_t vt[$];

    task automatic add(input bit r, input logic [31:0] a, input bit w, input bit rs,
                       input bit v, input logic [31:0] d, input bit e, input bit x,
                       input bit k, input bit h, input logic [7:0] c);
        vec_t t;
        t.req = r; t.addr = a; t.we = w; t.rsm = rs; t.v = v; t.d = d;
        t.e = e; t.x = x; t.k = k; t.h = h; t.c = c;
        vt.push_back(t);
    endtask

    // Reference model: core parked flag, pending resume flag, response schedule
    typedef struct {
        int          due;
        logic [31:0] data;
        bit          err;
        bit          exc;
        bit          ack;
    } exp_t;
    exp_t q[$];
    bit   m_parked;
    bit   m_pend;
    int   m_cnt;
    int   cyc;

    task automatic model_accept(input bit r, input logic [31:0] a, input bit w, input bit rs);
        exp_t e;
        bit   was_halted;
        was_halted = m_parked && !m_pend;
        e.due = cyc + 1; e.data = 32'd0; e.err = 1'b0; e.exc = 1'b0; e.ack = 1'b0;
        if (r) begin
            if (w || (a - 32'd1) >= 32'd256) begin
                e.err = 1'b1;
            end else if (a == 32'd11) begin
                if (m_pend) begin
                    e.data = DRET; e.ack = 1'b1; m_parked = 1'b0; m_pend = 1'b0;
                end else begin
                    e.data = LOOP; m_parked = 1'b1;
                end
            end else if (a == 32'd13) begin
                e.data = LOOP; e.exc = 1'b1; m_parked = 1'b1; m_pend = 1'b0;
                if (m_cnt < 255) m_cnt++;
            end else begin
                e.data = NOP;
            end
            q.push_back(e);
        end
        if (rs && was_halted && !e.exc) m_pend = 1'b1;
    endtask

    task automatic run_cycle(input bit r, input logic [31:0] a, input bit w, input bit rs);
        exp_t e;
        req = r; addr = a; we = w; rsm = rs;
        #1;
        chk1("rnd_gnt", gnt, r);
        model_accept(r, a, w, rs);
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk1("rnd_rvalid", rvalid, 1'b1);
            chk32("rnd_rdata", rdata, e.data);
            chk1("rnd_err", err, e.err);
            chk1("rnd_exc", exc, e.exc);
            chk1("rnd_ack", rack, e.ack);
        end else begin
            chk1("rnd_rvalid_idle", rvalid, 1'b0);
            chk32("rnd_rdata_idle", rdata, 32'd0);
            chk1("rnd_exc_idle", exc, 1'b0);
            chk1("rnd_ack_idle", rack, 1'b0);
        end
        chk1("rnd_halted", halted, m_parked);
        chk32("rnd_cnt", {24'd0, cnt}, m_cnt[31:0]);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; rsm = 1'b0; addr = 32'd0;
        req3 = 1'b0; we3 = 1'b0; rsm3 = 1'b0; addr3 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_rvalid", rvalid, 1'b0);
        chk32("rst_rdata", rdata, 32'd0);
        chk1("rst_halted", halted, 1'b0);
        chk32("rst_cnt", {24'd0, cnt}, 32'd0);
        req = 1'b1;
        #1;
        chk1("rst_gnt", gnt, 1'b1);
        req = 1'b0;
        rst = 1'b0;
        q.delete();
        m_parked = 1'b0; m_pend = 1'b0; m_cnt = 0;
    endtask

    int          sel;
    logic [31:0] ra;

    initial begin
        rst = 1'b1; be = 4'hF; wdata = 32'hDEADBEEF; cyc = 0;
        req = 1'b0; we = 1'b0; rsm = 1'b0; addr = 32'd0;
        req3 = 1'b0; we3 = 1'b0; rsm3 = 1'b0; addr3 = 32'd0;

        add(I, 32'd11,     O, O, I, LOOP,  O, O, O, I, 8'd0);
        add(I, 32'h40,     O, O, I, NOP,   O, O, O, I, 8'd0);
        add(O, 32'd0,      O, I, O, 32'd0, O, O, O, I, 8'd0);
        add(I, 32'd11,     O, O, I, DRET,  O, O, I, O, 8'd0);
        add(I, 32'd11,     O, O, I, LOOP,  O, O, O, I, 8'd0);
        add(I, 32'd11,     I, O, I, 32'd0, I, O, O, I, 8'd0);
        add(I, 32'h1000,   O, O, I, 32'd0, I, O, O, I, 8'd0);
        add(I, 32'd13,     O, O, I, LOOP,  O, I, O, I, 8'd1);
        add(I, 32'd0,      O, O, I, 32'd0, I, O, O, I, 8'd1);
        add(I, 32'd256,    O, O, I, NOP,   O, O, O, I, 8'd1);
        add(I, 32'd257,    O, O, I, 32'd0, I, O, O, I, 8'd1);
        add(O, 32'd0,      O, O, O, 32'd0, O, O, O, I, 8'd1);
        add(I, 32'd11,     O, I, I, LOOP,  O, O, O, I, 8'd1);
        add(I, 32'd13,     O, O, I, LOOP,  O, I, O, I, 8'd2);
        add(I, 32'd11,     O, O, I, LOOP,  O, O, O, I, 8'd2);
        add(O, 32'd0,      O, I, O, 32'd0, O, O, O, I, 8'd2);
        add(O, 32'd0,      O, I, O, 32'd0, O, O, O, I, 8'd2);
        add(I, 32'd11,     O, O, I, DRET,  O, O, I, O, 8'd2);
        add(O, 32'd0,      O, I, O, 32'd0, O, O, O, O, 8'd2);
        add(I, 32'h40,     O, O, I, NOP,   O, O, O, O, 8'd2);
        add(I, 32'd11,     O, O, I, LOOP,  O, O, O, I, 8'd2);

        do_reset();
        for (int i = 0; i < vt.size(); i++) begin
            req = vt[i].req; addr = vt[i].addr; we = vt[i].we; rsm = vt[i].rsm;
            #1;
            chk1($sformatf("tbl%0d_gnt", i), gnt, vt[i].req);
            @(posedge clk);
            #1;
            chk1($sformatf("tbl%0d_rvalid", i), rvalid, vt[i].v);
            chk32($sformatf("tbl%0d_rdata", i), rdata, vt[i].d);
            chk1($sformatf("tbl%0d_err", i), err, vt[i].e);
            chk1($sformatf("tbl%0d_exc", i), exc, vt[i].x);
            chk1($sformatf("tbl%0d_ack", i), rack, vt[i].k);
            chk1($sformatf("tbl%0d_halted", i), halted, vt[i].h);
            chk32($sformatf("tbl%0d_cnt", i), {24'd0, cnt}, {24'd0, vt[i].c});
        end
        req = 1'b0; rsm = 1'b0; we = 1'b0;

        do_reset();
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0, 1:    ra = 32'd11;
                2:       ra = 32'd13;
                3:       ra = $urandom_range(0, 300);
                4:       ra = 32'd0;
                5:       ra = 32'd256 + $urandom_range(0, 1);
                6:       ra = $urandom;
                default: ra = 32'h40;
            endcase
            run_cycle(($urandom_range(0, 3) != 0), ra, ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0));
        end

        do_reset();
        for (int n = 0; n < 300; n++) begin
            run_cycle(1'b1, 32'd13, 1'b0, 1'b0);
        end
        req = 1'b0;
        chk32("exc_saturate", {24'd0, cnt}, 32'd255);

        // Latency 3: back-to-back reads at 11, 13, 0x20 return in order on +3, +4, +5
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            case (k)
                1:       begin req3 = 1'b1; addr3 = 32'd11;  end
                2:       begin req3 = 1'b1; addr3 = 32'd13;  end
                3:       begin req3 = 1'b1; addr3 = 32'h20;  end
                default: begin req3 = 1'b0; addr3 = 32'd0;   end
            endcase
            @(posedge clk);
            #1;
            chk1($sformatf("lat3_rvalid_c%0d", k), rvalid3, (k >= 3 && k <= 5));
            chk32($sformatf("lat3_rdata_c%0d", k), rdata3,
                  (k == 3 || k == 4) ? LOOP : (k == 5) ? NOP : 32'd0);
            chk1($sformatf("lat3_exc_c%0d", k), exc3, (k == 4));
            chk1($sformatf("lat3_err_c%0d", k), err3, 1'b0);
        end

        // Mid-flight reset: two accepted reads must never come back
        req3 = 1'b1; addr3 = 32'd13;
        repeat (2) @(posedge clk);
        #1;
        req3 = 1'b0; rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk1($sformatf("midrst_rvalid_r%0d", k), rvalid3, 1'b0);
        end
        chk1("midrst_halted", halted3, 1'b0);
        chk32("midrst_cnt", {24'd0, cnt3}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk1($sformatf("midrst_after_rvalid_%0d", k), rvalid3, 1'b0);
        end
        chk1("midrst_after_halted", halted3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
